// File: rtl/sifh_peak_finder.sv
// sifh_peak_finder: after histogram acquisition, streams every {pixel, bin}
// word out of the shared RAM, reports the argmax bin of each pixel and can
// zero each word one cycle after reading it.
module sifh_peak_finder #(
    parameter int PIX_W    = 2,
    parameter int BIN_W    = 3,
    parameter int NB       = PIX_W + BIN_W,
    parameter int PEAK_MAX = 8
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic                clear_en,
    output logic                busy,
    output logic                done,
    output logic [NB-1:0]       raddr,
    output logic                rEnable,
    input  logic [PEAK_MAX-1:0] rdata,
    output logic [NB-1:0]       waddr,
    output logic                wEnable,
    output logic [PEAK_MAX-1:0] wdata,
    output logic                peak_valid,
    output logic [PIX_W-1:0]    peak_pixel,
    output logic [BIN_W-1:0]    peak_bin,
    output logic [PEAK_MAX-1:0] peak_count
);

    localparam int BINS = 2 ** BIN_W;
    localparam int N    = (2 ** PIX_W) * BINS;
    localparam logic [NB-1:0]    LAST_ADDR = NB'(N - 1);
    localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(BINS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [NB-1:0] cnt_q, cnt_d;
    logic          clear_q, clear_d;

    // Read-data tag: address and validity of the beat arriving this cycle.
    logic                rd_valid_q;
    logic [NB-1:0]       rd_addr_q;

    // Running maximum of the pixel currently streaming in.
    logic [PEAK_MAX-1:0] max_cnt_q, max_cnt_d;
    logic [BIN_W-1:0]    max_bin_q, max_bin_d;
    logic [BIN_W-1:0]    beat_bin;

    logic                peak_valid_q, done_q;
    logic [PIX_W-1:0]    peak_pixel_q;
    logic [BIN_W-1:0]    peak_bin_q;
    logic [PEAK_MAX-1:0] peak_count_q;

    // FSM state, read address counter and the clear mode latched at start.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clear_q <= clear_d;
        end
    end

    // Next-state logic and read-port drive; start is only honoured in IDLE.
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clear_d = clear_q;
        busy    = (state_q != ST_IDLE);
        rEnable = 1'b0;
        raddr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    clear_d = clear_en;
                end
            end
            ST_SCAN: begin
                rEnable = 1'b1;
                raddr   = cnt_q;
                cnt_d   = cnt_q + NB'(1);
                if (cnt_q == LAST_ADDR) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The final peak and done leave together; return once they have.
                if (done_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Compare: bin 0 loads unconditionally, later bins win only if strictly greater.
    always_comb begin
        beat_bin  = rd_addr_q[BIN_W-1:0];
        max_cnt_d = max_cnt_q;
        max_bin_d = max_bin_q;
        if ((beat_bin == '0) || (rdata > max_cnt_q)) begin
            max_cnt_d = rdata;
            max_bin_d = beat_bin;
        end
    end

    // Read tag pipeline, running max and the registered per-pixel result.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rd_valid_q   <= 1'b0;
            rd_addr_q    <= '0;
            max_cnt_q    <= '0;
            max_bin_q    <= '0;
            peak_valid_q <= 1'b0;
            done_q       <= 1'b0;
            peak_pixel_q <= '0;
            peak_bin_q   <= '0;
            peak_count_q <= '0;
        end else begin
            rd_valid_q   <= rEnable;
            rd_addr_q    <= raddr;
            peak_valid_q <= 1'b0;
            done_q       <= 1'b0;
            if (rd_valid_q) begin
                max_cnt_q <= max_cnt_d;
                max_bin_q <= max_bin_d;
                if (beat_bin == LAST_BIN) begin
                    peak_valid_q <= 1'b1;
                    peak_pixel_q <= rd_addr_q[BIN_W +: PIX_W];
                    peak_bin_q   <= max_bin_d;
                    peak_count_q <= max_cnt_d;
                    done_q       <= (rd_addr_q == LAST_ADDR);
                end
            end
        end
    end

    // The clear write trails the read by one cycle, so it never hits the word
    // being read in the same cycle.
    assign wEnable    = rd_valid_q & clear_q;
    assign waddr      = wEnable ? rd_addr_q : '0;
    assign wdata      = '0;

    assign peak_valid = peak_valid_q;
    assign done       = done_q;
    assign peak_pixel = peak_pixel_q;
    assign peak_bin   = peak_bin_q;
    assign peak_count = peak_count_q;

endmodule

// File: tb/tb_sifh_peak_finder.sv
// Bench for sifh_peak_finder: a 1-cycle-latency dual-port RAM model, a table of
// directed histograms, reset/restart sequences and random histograms checked
// against an argmax reference.
module tb_sifh_peak_finder;

    localparam int PIX_W  = 1;
    localparam int BIN_W  = 3;
    localparam int NB     = 4;
    localparam int PW     = 8;
    localparam int BINS   = 8;
    localparam int PIXELS = 2;
    localparam int N      = 16;

    typedef logic [N*PW-1:0] hist_t;
    typedef logic [PIXELS-1:0][BIN_W-1:0] bins_t;
    typedef logic [PIXELS-1:0][PW-1:0]    cnts_t;

    typedef struct {
        hist_t hist;
        bit    clr;
        bins_t ebin;
        cnts_t ecnt;
    } vec_t;

    logic              clk = 1'b0;
    logic              res, start, clear_en;
    logic              busy, done, rEnable, wEnable, peak_valid;
    logic [NB-1:0]     raddr, waddr;
    logic [PW-1:0]     rdata = '0;
    logic [PW-1:0]     wdata, peak_count;
    logic [PIX_W-1:0]  peak_pixel;
    logic [BIN_W-1:0]  peak_bin;

    logic [PW-1:0]     mem [N];
    logic              tb_we;
    logic [NB-1:0]     tb_addr;
    logic [PW-1:0]     tb_data;

    int checks = 0;
    int errors = 0;
    vec_t vecs [5];

    sifh_peak_finder #(
        .PIX_W(PIX_W), .BIN_W(BIN_W), .NB(NB), .PEAK_MAX(PW)
    ) dut (
        .clk(clk), .res(res), .start(start), .clear_en(clear_en),
        .busy(busy), .done(done), .raddr(raddr), .rEnable(rEnable),
        .rdata(rdata), .waddr(waddr), .wEnable(wEnable), .wdata(wdata),
        .peak_valid(peak_valid), .peak_pixel(peak_pixel),
        .peak_bin(peak_bin), .peak_count(peak_count)
    );

    always #5 clk = ~clk;

    // Dual-port RAM: registered read on port B, DUT clear or bench preload on port A.
    always @(posedge clk) begin
        if (rEnable) rdata <= mem[raddr];
        if (wEnable) mem[waddr] <= wdata;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic hist_t fill(input logic [PW-1:0] v0, input logic [PW-1:0] v1);
        hist_t h;
        for (int a = 0; a < N; a++) h[a*PW +: PW] = (a < BINS) ? v0 : v1;
        return h;
    endfunction

    function automatic hist_t set_bin(input hist_t h, input int a, input logic [PW-1:0] v);
        hist_t r;
        r = h;
        r[a*PW +: PW] = v;
        return r;
    endfunction

    // Reference: find the largest count, then the lowest bin holding it.
    function automatic void model(input hist_t h, output bins_t b, output cnts_t c);
        logic [PW-1:0] mx;
        for (int p = 0; p < PIXELS; p++) begin
            mx = '0;
            for (int k = 0; k < BINS; k++)
                if (h[(p*BINS+k)*PW +: PW] > mx) mx = h[(p*BINS+k)*PW +: PW];
            b[p] = '0;
            for (int k = BINS-1; k >= 0; k--)
                if (h[(p*BINS+k)*PW +: PW] == mx) b[p] = BIN_W'(k);
            c[p] = mx;
        end
    endfunction

    task automatic load_ram(input hist_t h);
        for (int a = 0; a < N; a++) begin
            @(negedge clk);
            tb_we   = 1'b1;
            tb_addr = NB'(a);
            tb_data = h[a*PW +: PW];
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic verify_mem(input hist_t h, input bit clr);
        logic [PW-1:0] e;
        for (int a = 0; a < N; a++) begin
            e = clr ? '0 : h[a*PW +: PW];
            check($sformatf("mem[%0d]", a), 64'(mem[a]), 64'(e));
        end
    endtask

    // Start a scan at cycle 0 and check every output cycle by cycle through N+3.
    task automatic run_scan(input bit clr, input bins_t ebin, input cnts_t ecnt, input int restart_at);
        logic [12:0] act, exp;
        bit e_busy, e_ren, e_wen, e_pv, e_done;
        int p;
        @(negedge clk);
        start = 1'b1;
        clear_en = clr;
        @(negedge clk);
        for (int c = 1; c <= N + 3; c++) begin
            start    = (c == restart_at);
            clear_en = (c == restart_at) ? ~clr : 1'b0;
            e_busy = (c <= N + 2);
            e_ren  = (c <= N);
            e_wen  = clr && (c >= 2) && (c <= N + 1);
            e_pv   = (c >= BINS + 2) && (c <= N + 2) && (((c - 2) % BINS) == 0);
            e_done = (c == N + 2);
            act = {busy, rEnable, rEnable ? raddr : 4'd0, wEnable, wEnable ? waddr : 4'd0,
                   peak_valid, done};
            exp = {e_busy, e_ren, e_ren ? NB'(c - 1) : 4'd0, e_wen, e_wen ? NB'(c - 2) : 4'd0,
                   e_pv, e_done};
            check($sformatf("ctrl cycle %0d", c), 64'(act), 64'(exp));
            check($sformatf("wdata cycle %0d", c), 64'(wdata), 64'd0);
            if (e_pv) begin
                p = (c - 2) / BINS - 1;
                check($sformatf("pixel cycle %0d", c), 64'(peak_pixel), 64'(p));
                check($sformatf("bin pixel %0d", p), 64'(peak_bin), 64'(ebin[p]));
                check($sformatf("count pixel %0d", p), 64'(peak_count), 64'(ecnt[p]));
            end
            @(negedge clk);
        end
        start    = 1'b0;
        clear_en = 1'b0;
    endtask

    initial begin
        bins_t rb;
        cnts_t rc;
        hist_t h;
        bit    clr;
        int    mode;

        // Directed table.
        vecs[0].hist = set_bin(set_bin(fill(8'd1, 8'd0), 5, 8'd7), BINS + 2, 8'd3);
        vecs[0].clr  = 1'b0;
        vecs[0].ebin[0] = 3'd5; vecs[0].ecnt[0] = 8'd7;
        vecs[0].ebin[1] = 3'd2; vecs[0].ecnt[1] = 8'd3;

        vecs[1].hist = set_bin(set_bin(fill(8'd2, 8'd4), 3, 8'd9), 6, 8'd9);
        vecs[1].clr  = 1'b0;
        vecs[1].ebin[0] = 3'd3; vecs[1].ecnt[0] = 8'd9;
        vecs[1].ebin[1] = 3'd0; vecs[1].ecnt[1] = 8'd4;

        vecs[2].hist = fill(8'd0, 8'd0);
        vecs[2].clr  = 1'b0;
        vecs[2].ebin[0] = 3'd0; vecs[2].ecnt[0] = 8'd0;
        vecs[2].ebin[1] = 3'd0; vecs[2].ecnt[1] = 8'd0;

        h = fill(8'd0, 8'd254);
        for (int k = 0; k < BINS; k++) h = set_bin(h, k, PW'(k * 10));
        vecs[3].hist = set_bin(h, N - 1, 8'd255);
        vecs[3].clr  = 1'b0;
        vecs[3].ebin[0] = 3'd7; vecs[3].ecnt[0] = 8'd70;
        vecs[3].ebin[1] = 3'd7; vecs[3].ecnt[1] = 8'd255;

        vecs[4] = vecs[0];
        vecs[4].clr = 1'b1;

        res = 1'b1; start = 1'b0; clear_en = 1'b0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        @(negedge clk);
        check("reset outputs",
              64'({busy, done, raddr, rEnable, waddr, wEnable, wdata,
                   peak_valid, peak_pixel, peak_bin, peak_count}), 64'd0);
        res = 1'b0;

        for (int i = 0; i < 5; i++) begin
            load_ram(vecs[i].hist);
            run_scan(vecs[i].clr, vecs[i].ebin, vecs[i].ecnt, -1);
            verify_mem(vecs[i].hist, vecs[i].clr);
        end

        // Second start during the scan must not disturb it or re-sample clear_en.
        load_ram(vecs[0].hist);
        run_scan(1'b0, vecs[0].ebin, vecs[0].ecnt, 5);
        verify_mem(vecs[0].hist, 1'b0);

        // Reset at cycle 7 mid-scan, then a fresh full scan.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 7; c++) @(negedge clk);
        res = 1'b1;
        #1;
        check("mid-scan reset outputs",
              64'({busy, done, raddr, rEnable, waddr, wEnable, wdata,
                   peak_valid, peak_pixel, peak_bin, peak_count}), 64'd0);
        @(negedge clk);
        res = 1'b0;
        for (int c = 0; c < N + 4; c++) begin
            check($sformatf("quiet after reset %0d", c),
                  64'({busy, peak_valid, done, rEnable, wEnable}), 64'd0);
            @(negedge clk);
        end
        run_scan(1'b0, vecs[0].ebin, vecs[0].ecnt, -1);

        // Random histograms against the argmax reference.
        for (int it = 0; it < 10; it++) begin
            mode = int'($urandom_range(0, 2));
            for (int a = 0; a < N; a++) begin
                case (mode)
                    0:       h[a*PW +: PW] = PW'($urandom_range(0, 3));
                    1:       h[a*PW +: PW] = PW'($urandom_range(0, 255));
                    default: h[a*PW +: PW] = PW'($urandom_range(250, 255));
                endcase
            end
            clr = bit'($urandom_range(0, 1));
            model(h, rb, rc);
            load_ram(h);
            run_scan(clr, rb, rc, -1);
            verify_mem(h, clr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sifh_peak_finder.md
# sifh_peak_finder

Post-acquisition stage directly downstream of the SiFH histogram builder. When the builder signals that acquisition is complete, this block scans every pixel's histogram in the shared dual-port RAM through the read port. For each pixel it reports the bin with the highest count. If requested, it also writes each bin back to zero as it goes, so the RAM is ready for the next acquisition frame.

## Interface
Parameters:
- PIX_W, default 2: pixel index width; PIXELS = 2**PIX_W.
- BIN_W, default 3: bin index width; BINS = 2**BIN_W.
- NB, default PIX_W+BIN_W: RAM address width; address = {pixel, bin}.
- PEAK_MAX, default 8: histogram count width.

Ports:
- clk  in  1  single clock.
- res  in  1  asynchronous reset, active-high.
- start  in  1  acquisition-complete pulse from the histogram FSM.
- clear_en  in  1  sampled together with start; 1 = zero each bin after reading it.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse on the final result.
- raddr  out  NB  RAM port-B address.
- rEnable  out  1  RAM port-B read enable.
- rdata  in  PEAK_MAX  RAM port-B data, valid 1 cycle after the read.
- waddr  out  NB  RAM port-A address, used for clearing.
- wEnable  out  1  RAM port-A write enable.
- wdata  out  PEAK_MAX  always 0.
- peak_valid  out  1  one-cycle strobe per pixel.
- peak_pixel  out  PIX_W  pixel index of the result.
- peak_bin  out  BIN_W  argmax bin of that pixel.
- peak_count  out  PEAK_MAX  count at peak_bin.

## Operation
- States:
  - IDLE: waits for start.
  - SCAN: issues reads.
  - DRAIN: waits for the last RAM data and emits the last peak.
  - Transitions: IDLE→SCAN on start; SCAN→DRAIN after the last read; DRAIN→IDLE after done.
- Reads:
  - In SCAN, rEnable=1 and raddr steps 0,1,…,N−1, where N = PIXELS·BINS.
  - One read per cycle, no gaps.
- Compare pipeline:
  - Each rdata beat is tagged with its delayed address.
  - At bin 0 of a pixel, max is loaded unconditionally with (bin 0, rdata).
  - For later bins, max updates only if rdata > current max (strictly greater).
  - Ties therefore resolve to the lowest bin index.
  - An all-zero histogram reports bin 0, count 0.
- Emit:
  - The cycle after a pixel's last-bin data arrives, peak_valid=1 with that pixel's {pixel, bin, count}.
  - There is no backpressure; the consumer must accept every strobe.
- Clear:
  - If clear_en was latched, then in the cycle each rdata beat arrives: wEnable=1, waddr = that beat's address, wdata=0.
  - If clear_en was latched as 0, wEnable is never asserted.
- Comparisons are unsigned at full PEAK_MAX width; counts are never modified except by clearing.

## Timing
- Reference point: start is sampled high in IDLE at cycle 0.
- Read of address a occurs in cycle a+1, so reads cover cycles 1…N.
- rdata for address a is valid in cycle a+2; the clear write for a also happens in cycle a+2.
- peak_valid for pixel p occurs in cycle (p+1)·BINS+2.
- done is asserted together with the last peak_valid, in cycle N+2.
- busy is 1 in cycles 1…N+2 and 0 from cycle N+3.
- A new start is accepted from cycle N+3 onward.
- start while busy=1 is ignored. clear_en is only sampled with an accepted start.
- Read and clear never target the same address in the same cycle: the clear lags the read by one cycle, which is safe for a 1-cycle-latency dual-port RAM.
- Reset values, all 0: busy, done, raddr, rEnable, waddr, wEnable, wdata, peak_valid, peak_pixel, peak_bin, peak_count, plus internal max/bin/state.
- Reset mid-scan:
  - Returns to IDLE immediately; no further peak_valid or done.
  - RAM is left partially cleared; the upstream FSM owns re-initialisation.
  - The next start after reset performs a full scan.

## Test plan
1. Single peak (PIX_W=1, BIN_W=3, N=16). Pixel 0: bin5=7, other bins 1. Pixel 1: bin2=3, other bins 0. Pulse start at cycle 0 → peak_valid (0,5,7) at cycle 10, (1,2,3) at cycle 18, done at cycle 18, busy low at cycle 19.
2. Tie-break: pixel 0 bins 3 and 6 both 9 → peak_bin=3, peak_count=9.
3. Empty histogram: all zeros → every pixel reports bin 0, count 0; exactly PIXELS strobes.
4. Clear:
   - clear_en=1 → 16 wEnable cycles, in cycles 2…17, waddr 0…15, wdata 0; a later readback is all zero.
   - Rerun with clear_en=0 → wEnable stays 0 and RAM is unchanged.
5. Robustness:
   - Pulse start again at cycle 5 → ignored; output timing identical to scenario 1.
   - Assert res at cycle 7 → all outputs 0 next edge, no done; fresh start after reset gives scenario 1 results.
6. Saturated count: 255 in pixel 1 bin 7 with PEAK_MAX=8 → (1,7,255) reported in cycle 18.
